// File: rtl/calc_display_pkg.sv
// Shared types and segment encodings for the calculator's 7-segment display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low, for a common-anode display.
package calc_display_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [1:0] digit_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      COMMIT
   } conv_state_t;

   localparam seg_t SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   localparam seg_t SEG_MINUS = 7'b0111111;
   localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter, one double-dabble step per clock.
// state   | meaning
// IDLE    | waiting for start; captures bin and clears the BCD digits
// CONVERT | six add-3/shift steps, iteration counter counts down to 1
// COMMIT  | tens/ones are final; done pulses for one cycle
module bin_to_bcd_seq
   import calc_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   conv_state_t state, state_nxt;
   logic [13:0] shift_q, shift_nxt, adj;
   logic [2:0]  iter_q, iter_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_q <= '0;
         iter_q  <= '0;
      end else begin
         state   <= state_nxt;
         shift_q <= shift_nxt;
         iter_q  <= iter_nxt;
      end
   end

   always_comb begin
      adj = shift_q;
      if (shift_q[13:10] >= 4'd5) adj[13:10] = shift_q[13:10] + 4'd3;
      if (shift_q[9:6] >= 4'd5)   adj[9:6]   = shift_q[9:6] + 4'd3;
   end

   always_comb begin
      state_nxt = state;
      shift_nxt = shift_q;
      iter_nxt  = iter_q;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               shift_nxt = {8'h00, bin};
               iter_nxt  = 3'd6;
               state_nxt = CONVERT;
            end
         end
         CONVERT: begin
            shift_nxt = {adj[12:0], 1'b0};
            iter_nxt  = iter_q - 3'd1;
            if (iter_q == 3'd1) state_nxt = COMMIT;
         end
         COMMIT: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tens = shift_q[13:10];
   assign ones = shift_q[9:6];

endmodule

// File: rtl/seg_display_driver.sv
// 4-digit multiplexed 7-segment driver: change-triggered BCD conversion into a
// double-buffered digit store, scanned out with leading-zero blanking and a floating minus.
module seg_display_driver
   import calc_display_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int REFRESH_HZ  = 1000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] value,
   input  logic       negative,
   output logic [3:0] an,
   output seg_t       seg,
   output logic       dp
);

   localparam int DIV   = CLK_FREQ_HZ / (REFRESH_HZ * 4);
   localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("seg_display_driver: scan divider must be at least 2");
      end
   endgenerate

   logic [6:0] committed, work_pair;
   logic       valid, busy, start, done, show_sign;
   logic [3:0] tens, ones;
   seg_t       digit_buf [4];

   logic [CNT_W-1:0] scan_cnt;
   digit_idx_t       idx;

   // Only launch while the converter is idle so a mid-conversion input change waits its turn.
   assign start     = !busy && (!valid || ({negative, value} != committed));
   assign show_sign = work_pair[6] && (work_pair[5:0] != 6'd0);

   bin_to_bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (value),
      .done  (done),
      .tens  (tens),
      .ones  (ones)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         committed <= '0;
         work_pair <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < 4; i++) digit_buf[i] <= SEG_BLANK;
      end else begin
         if (start) begin
            work_pair <= {negative, value};
            busy      <= 1'b1;
         end
         if (done) begin
            busy         <= 1'b0;
            valid        <= 1'b1;
            committed    <= work_pair;
            digit_buf[0] <= SEG_DIGIT[ones];
            digit_buf[1] <= (tens != 4'd0) ? SEG_DIGIT[tens] : (show_sign ? SEG_MINUS : SEG_BLANK);
            digit_buf[2] <= ((tens != 4'd0) && show_sign) ? SEG_MINUS : SEG_BLANK;
            digit_buf[3] <= SEG_BLANK;
         end
      end
   end

   // Anode and segments are registered together so they switch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= 4'b1111;
         seg      <= SEG_BLANK;
      end else begin
         if (scan_cnt == CNT_W'(DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
         end
         an  <= ~(4'b0001 << idx);
         seg <= digit_buf[idx];
      end
   end

   assign dp = 1'b1;

endmodule
